// File: rtl/bus16_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus16 arbiter interfaces
//
// bus16_req_if : link between one bus master and the arbiter.
//   cs       master -> arb  one-cycle request pulse
//   wr_rd_n  master -> arb  1 = write, 0 = read (valid with cs)
//   addr8    master -> arb  16-bit byte address (valid with cs)
//   wr_data  master -> arb  16-bit write data (valid with cs)
//   rd_data  arb -> master  read data, valid with rd_dv, held otherwise
//   rd_dv    arb -> master  one-cycle read-return pulse
//   busy     arb -> master  request pending or in flight
//   drop     arb -> master  one-cycle pulse: request rejected while busy
//
// bus16_slv_if : link between the arbiter and the shared register slave.
//   cs, wr_rd_n, addr8, wr_data  arb -> slave
//   rd_data, rd_dv               slave -> arb
// ---------------------------------------------------------------------------
interface bus16_req_if;
  logic        cs;
  logic        wr_rd_n;
  logic [15:0] addr8;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_dv;
  logic        busy;
  logic        drop;

  modport master (output cs, wr_rd_n, addr8, wr_data,
                  input  rd_data, rd_dv, busy, drop);
  modport slave  (input  cs, wr_rd_n, addr8, wr_data,
                  output rd_data, rd_dv, busy, drop);
endinterface

interface bus16_slv_if;
  logic        cs;
  logic        wr_rd_n;
  logic [15:0] addr8;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_dv;

  modport master (output cs, wr_rd_n, addr8, wr_data,
                  input  rd_data, rd_dv);
  modport slave  (input  cs, wr_rd_n, addr8, wr_data,
                  output rd_data, rd_dv);
endinterface

// File: rtl/bus16_arbiter.sv
// ---------------------------------------------------------------------------
// bus16_arbiter
//
// Shares one 16-bit byte-addressed register slave between two masters.
// Each master's one-cycle request is buffered (one deep), the buffered
// requests are served round-robin, and the winner is replayed to the slave
// as a one-cycle cs pulse. Read data is routed back to the requester only;
// a read the slave never answers returns TIMEOUT_DATA after RD_TIMEOUT
// cycles in WAIT_RD.
//
// Ports:
//   clk      in   bus clock, all logic rising-edge
//   rst      in   asynchronous active-high reset
//   m0, m1   req  master links (slave side of bus16_req_if)
//   bus      slv  shared slave link (master side of bus16_slv_if)
//   grant    out  master owning the current/last transaction (0=M0, 1=M1)
//   timeout  out  one-cycle pulse when a read times out
// ---------------------------------------------------------------------------
module bus16_arbiter #(
  parameter int          RD_TIMEOUT   = 64,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic          clk,
  input  logic          rst,
  bus16_req_if.slave    m0,
  bus16_req_if.slave    m1,
  bus16_slv_if.master   bus,
  output logic          grant,
  output logic          timeout
);

  localparam int CW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  typedef struct packed {
    logic        wr_rd_n;
    logic [15:0] addr8;
    logic [15:0] wr_data;
  } req_t;

  state_t        state, state_d;
  logic [1:0]    pending;
  req_t          buf_q [2];
  logic          rr_last;
  logic [CW-1:0] cnt;

  logic          bus_cs_q;
  logic          bus_wr_rd_n_q;
  logic [15:0]   bus_addr8_q;
  logic [15:0]   bus_wr_data_q;
  logic [15:0]   rd_data_q [2];
  logic [1:0]    rd_dv_q;
  logic [1:0]    drop_q;
  logic          timeout_q;

  logic [1:0]    cs_in;
  req_t          req_in [2];

  // FSM decode strobes
  logic          grant_fire;
  logic          grant_sel;
  logic [1:0]    clr_pend;
  logic          rd_done;
  logic          tmo_fire;
  logic          cnt_clr;

  assign cs_in     = {m1.cs, m0.cs};
  assign req_in[0] = {m0.wr_rd_n, m0.addr8, m0.wr_data};
  assign req_in[1] = {m1.wr_rd_n, m1.addr8, m1.wr_data};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise any
    // path that skips an assignment would infer a latch.
    state_d    = state;
    grant_fire = 1'b0;
    grant_sel  = grant;
    clr_pend   = 2'b00;
    rd_done    = 1'b0;
    tmo_fire   = 1'b0;
    cnt_clr    = 1'b0;

    case (state)
      IDLE: begin
        if (pending != 2'b00) begin
          grant_fire = 1'b1;
          // On a tie, serve whoever was not served last; otherwise the only
          // pending master (pending[1] is 1 exactly when M1 alone waits).
          grant_sel  = (pending == 2'b11) ? ~rr_last : pending[1];
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (bus_wr_rd_n_q) begin
          clr_pend[grant] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_clr = 1'b1;
          state_d = WAIT_RD;
        end
      end

      WAIT_RD: begin
        // Slave data wins over a timeout falling in the same cycle.
        if (bus.rd_dv) begin
          rd_done         = 1'b1;
          clr_pend[grant] = 1'b1;
          state_d         = IDLE;
        end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
          tmo_fire        = 1'b1;
          clr_pend[grant] = 1'b1;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request capture, pending flags, drop pulses
  // -------------------------------------------------------------------------
  // NOTE: the two request buffers are reset along with everything else; they
  // are only two words, and reset-clean contents keep the slave fields
  // deterministic after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 2'b00;
      drop_q  <= 2'b00;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        drop_q[i] <= 1'b0;
        // A request arriving in the cycle its slot is freed is accepted.
        if (cs_in[i] && (!pending[i] || clr_pend[i])) begin
          buf_q[i]   <= req_in[i];
          pending[i] <= 1'b1;
        end else begin
          if (clr_pend[i]) pending[i] <= 1'b0;
          if (cs_in[i])    drop_q[i]  <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant, round-robin pointer, slave-side request fields
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= 1'b0;
      rr_last       <= 1'b1;   // M0 wins the first tie
      bus_cs_q      <= 1'b0;
      bus_wr_rd_n_q <= 1'b0;
      bus_addr8_q   <= '0;
      bus_wr_data_q <= '0;
    end else begin
      // cs is high for exactly the ISSUE cycle that follows a grant.
      bus_cs_q <= grant_fire;
      if (grant_fire) begin
        grant         <= grant_sel;
        rr_last       <= grant_sel;
        bus_wr_rd_n_q <= buf_q[grant_sel].wr_rd_n;
        bus_addr8_q   <= buf_q[grant_sel].addr8;
        bus_wr_data_q <= buf_q[grant_sel].wr_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read timeout counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (cnt_clr)         cnt <= '0;
    else if (state == WAIT_RD) cnt <= cnt + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Read return: only the granted master's outputs ever move
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dv_q   <= 2'b00;
      timeout_q <= 1'b0;
      for (int i = 0; i < 2; i++) rd_data_q[i] <= '0;
    end else begin
      rd_dv_q   <= 2'b00;
      timeout_q <= tmo_fire;
      if (rd_done || tmo_fire) begin
        rd_dv_q[grant]   <= 1'b1;
        rd_data_q[grant] <= rd_done ? bus.rd_data : TIMEOUT_DATA;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign bus.cs      = bus_cs_q;
  assign bus.wr_rd_n = bus_wr_rd_n_q;
  assign bus.addr8   = bus_addr8_q;
  assign bus.wr_data = bus_wr_data_q;

  assign m0.rd_data  = rd_data_q[0];
  assign m0.rd_dv    = rd_dv_q[0];
  assign m0.busy     = pending[0];
  assign m0.drop     = drop_q[0];

  assign m1.rd_data  = rd_data_q[1];
  assign m1.rd_dv    = rd_dv_q[1];
  assign m1.busy     = pending[1];
  assign m1.drop     = drop_q[1];

  assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus16_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for bus16_arbiter (RD_TIMEOUT=64, TIMEOUT_DATA=DEAD).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_bus16_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant;
  logic timeout;

  int total = 0;
  int bad   = 0;

  bus16_req_if m0_if ();
  bus16_req_if m1_if ();
  bus16_slv_if bus_if ();

  bus16_arbiter #(.RD_TIMEOUT(64), .TIMEOUT_DATA(16'hDEAD)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .bus     (bus_if),
    .grant   (grant),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Every DUT output in one vector, for reset checks.
  wire [73:0] all_outs = {bus_if.cs, bus_if.wr_rd_n, bus_if.addr8, bus_if.wr_data,
                          m0_if.rd_data, m0_if.rd_dv, m0_if.busy, m0_if.drop,
                          m1_if.rd_data, m1_if.rd_dv, m1_if.busy, m1_if.drop,
                          grant, timeout};

  // Pulse counters sampled mid-cycle.
  int bus_cs_n = 0, m0_dv_n = 0, m1_dv_n = 0, tmo_n = 0, m0_drop_n = 0;
  always @(negedge clk) begin
    if (bus_if.cs === 1'b1)  bus_cs_n++;
    if (m0_if.rd_dv === 1'b1) m0_dv_n++;
    if (m1_if.rd_dv === 1'b1) m1_dv_n++;
    if (timeout === 1'b1)    tmo_n++;
    if (m0_if.drop === 1'b1) m0_drop_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want < 200000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive_req(input bit m, input bit wr, input logic [15:0] a,
                           input logic [15:0] d);
    if (!m) begin
      m0_if.cs = 1'b1; m0_if.wr_rd_n = wr; m0_if.addr8 = a; m0_if.wr_data = d;
    end else begin
      m1_if.cs = 1'b1; m1_if.wr_rd_n = wr; m1_if.addr8 = a; m1_if.wr_data = d;
    end
  endtask

  task automatic clear_in();
    m0_if.cs = 1'b0;
    m1_if.cs = 1'b0;
    bus_if.rd_dv = 1'b0;
    bus_if.rd_data = 16'h0000;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (all_outs !== 74'd0) begin bad++; $display("FAIL reset_outs: got %h want 0", all_outs); end
    rst = 1'b0;
    smp();
    total++; if (all_outs !== 74'd0) begin bad++; $display("FAIL post_reset_outs: got %h want 0", all_outs); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_write();
    int dv0, dv1;
    dv0 = m0_dv_n; dv1 = m1_dv_n;
    drive_req(0, 1'b1, 16'h005A, 16'h0006);
    smp();
    total++; if (m0_if.busy !== 1'b0) begin bad++; $display("FAIL wr_busy_n: got %b want 0", m0_if.busy); end
    tick(); clear_in(); smp();
    total++; if ({m0_if.busy, bus_if.cs} !== 2'b10) begin bad++; $display("FAIL wr_busy_n1: got %b want 10", {m0_if.busy, bus_if.cs}); end
    tick(); smp();
    total++;
    if ({bus_if.cs, bus_if.wr_rd_n, bus_if.addr8, bus_if.wr_data, m0_if.busy, grant} !== {2'b11, 16'h005A, 16'h0006, 2'b10}) begin
      bad++; $display("FAIL wr_issue: got cs=%b wr=%b a=%h d=%h busy=%b g=%b want 1 1 005a 0006 1 0",
                      bus_if.cs, bus_if.wr_rd_n, bus_if.addr8, bus_if.wr_data, m0_if.busy, grant);
    end
    tick(); smp();
    total++; if ({m0_if.busy, bus_if.cs} !== 2'b00) begin bad++; $display("FAIL wr_done: got %b want 00", {m0_if.busy, bus_if.cs}); end
    total++; if ((m0_dv_n - dv0) + (m1_dv_n - dv1) !== 0) begin bad++; $display("FAIL wr_no_dv: got %0d want 0", (m0_dv_n - dv0) + (m1_dv_n - dv1)); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_read_routing();
    int dv0;
    dv0 = m0_dv_n;
    drive_req(1, 1'b0, 16'h0014, 16'h0000);
    tick(); clear_in();
    tick(); smp();
    total++;
    if ({bus_if.cs, bus_if.wr_rd_n, bus_if.addr8, grant} !== {2'b10, 16'h0014, 1'b1}) begin
      bad++; $display("FAIL rd_issue: got cs=%b wr=%b a=%h g=%b want 1 0 0014 1", bus_if.cs, bus_if.wr_rd_n, bus_if.addr8, grant);
    end
    repeat (5) tick();
    bus_if.rd_dv = 1'b1; bus_if.rd_data = 16'hBEEF;
    smp();
    total++; if (m1_if.rd_dv !== 1'b0) begin bad++; $display("FAIL rd_dv_early: got %b want 0", m1_if.rd_dv); end
    tick(); clear_in(); smp();
    total++;
    if ({m1_if.rd_dv, m1_if.rd_data, m0_if.rd_dv, m1_if.busy, grant} !== {1'b1, 16'hBEEF, 3'b001}) begin
      bad++; $display("FAIL rd_return: got dv1=%b d=%h dv0=%b busy1=%b g=%b want 1 beef 0 0 1",
                      m1_if.rd_dv, m1_if.rd_data, m0_if.rd_dv, m1_if.busy, grant);
    end
    tick(); smp();
    total++; if ({m1_if.rd_dv, m1_if.rd_data} !== {1'b0, 16'hBEEF}) begin bad++; $display("FAIL rd_hold: got %b %h want 0 beef", m1_if.rd_dv, m1_if.rd_data); end
    total++; if (m0_dv_n !== dv0) begin bad++; $display("FAIL rd_m0_quiet: got %0d want %0d", m0_dv_n, dv0); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_contention();
    // Pair 1 after reset pointer / M1 last: M0 first, M1 two cycles later.
    drive_req(0, 1'b1, 16'h0100, 16'h1111);
    drive_req(1, 1'b1, 16'h0200, 16'h2222);
    tick(); clear_in();
    tick(); smp();
    total++; if ({bus_if.cs, bus_if.addr8, grant} !== {1'b1, 16'h0100, 1'b0}) begin bad++; $display("FAIL pair1_first: got cs=%b a=%h g=%b want 1 0100 0", bus_if.cs, bus_if.addr8, grant); end
    tick(); smp();
    total++; if (bus_if.cs !== 1'b0) begin bad++; $display("FAIL pair1_gap: got %b want 0", bus_if.cs); end
    tick(); smp();
    total++; if ({bus_if.cs, bus_if.addr8, bus_if.wr_data, grant} !== {1'b1, 16'h0200, 16'h2222, 1'b1}) begin bad++; $display("FAIL pair1_second: got cs=%b a=%h d=%h g=%b want 1 0200 2222 1", bus_if.cs, bus_if.addr8, bus_if.wr_data, grant); end
    tick(); tick();
    // M0 alone, so M0 becomes last served.
    drive_req(0, 1'b1, 16'h0300, 16'h3333);
    tick(); clear_in();
    tick(); smp();
    total++; if ({bus_if.cs, bus_if.addr8, grant} !== {1'b1, 16'h0300, 1'b0}) begin bad++; $display("FAIL solo_m0: got cs=%b a=%h g=%b want 1 0300 0", bus_if.cs, bus_if.addr8, grant); end
    tick(); tick();
    // Pair 2: M1 first now.
    drive_req(0, 1'b1, 16'h0400, 16'h4444);
    drive_req(1, 1'b1, 16'h0500, 16'h5555);
    tick(); clear_in();
    tick(); smp();
    total++; if ({bus_if.cs, bus_if.addr8, grant} !== {1'b1, 16'h0500, 1'b1}) begin bad++; $display("FAIL pair2_first: got cs=%b a=%h g=%b want 1 0500 1", bus_if.cs, bus_if.addr8, grant); end
    tick(); tick(); smp();
    total++; if ({bus_if.cs, bus_if.addr8, grant} !== {1'b1, 16'h0400, 1'b0}) begin bad++; $display("FAIL pair2_second: got cs=%b a=%h g=%b want 1 0400 0", bus_if.cs, bus_if.addr8, grant); end
    tick(); tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_drop();
    int cs0, dr0;
    dr0 = m0_drop_n;
    drive_req(0, 1'b0, 16'h00A0, 16'h0000);
    tick(); clear_in();
    tick(); smp();
    total++; if ({bus_if.cs, bus_if.wr_rd_n, bus_if.addr8} !== {2'b10, 16'h00A0}) begin bad++; $display("FAIL drop_issue: got cs=%b wr=%b a=%h want 1 0 00a0", bus_if.cs, bus_if.wr_rd_n, bus_if.addr8); end
    tick(); tick();
    drive_req(0, 1'b1, 16'h0BBB, 16'h0CCC);
    smp();
    total++; if (m0_if.drop !== 1'b0) begin bad++; $display("FAIL drop_early: got %b want 0", m0_if.drop); end
    tick(); clear_in(); smp();
    total++;
    if ({m0_if.drop, m0_if.busy, bus_if.wr_rd_n, bus_if.addr8} !== {3'b110, 16'h00A0}) begin
      bad++; $display("FAIL drop_pulse: got drop=%b busy=%b wr=%b a=%h want 1 1 0 00a0", m0_if.drop, m0_if.busy, bus_if.wr_rd_n, bus_if.addr8);
    end
    tick();
    bus_if.rd_dv = 1'b1; bus_if.rd_data = 16'h1234;
    smp();
    total++; if (m0_if.drop !== 1'b0) begin bad++; $display("FAIL drop_once: got %b want 0", m0_if.drop); end
    tick(); clear_in(); smp();
    total++; if ({m0_if.rd_dv, m0_if.rd_data} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL drop_rd: got %b %h want 1 1234", m0_if.rd_dv, m0_if.rd_data); end
    cs0 = bus_cs_n;
    repeat (4) tick();
    smp();
    total++; if ({bus_cs_n - cs0, 31'(m0_if.busy)} !== {32'd0, 31'd0}) begin bad++; $display("FAIL drop_discard: got cs_pulses=%0d busy=%b want 0 0", bus_cs_n - cs0, m0_if.busy); end
    total++; if (m0_drop_n - dr0 !== 1) begin bad++; $display("FAIL drop_count: got %0d want 1", m0_drop_n - dr0); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timeout();
    int t0, dv0;
    t0 = tmo_n; dv0 = m0_dv_n;
    drive_req(0, 1'b0, 16'h00C0, 16'h0000);
    tick(); clear_in();
    tick(); smp();
    total++; if (bus_if.cs !== 1'b1) begin bad++; $display("FAIL tmo_issue: got %b want 1", bus_if.cs); end
    repeat (64) tick();
    smp();
    total++; if ({m0_if.rd_dv, timeout} !== 2'b00) begin bad++; $display("FAIL tmo_early: got %b want 00", {m0_if.rd_dv, timeout}); end
    tick(); smp();
    total++;
    if ({m0_if.rd_dv, timeout, m0_if.rd_data, m0_if.busy} !== {2'b11, 16'hDEAD, 1'b0}) begin
      bad++; $display("FAIL tmo_fire: got dv=%b tmo=%b d=%h busy=%b want 1 1 dead 0", m0_if.rd_dv, timeout, m0_if.rd_data, m0_if.busy);
    end
    tick(); smp();
    total++; if ({m0_if.rd_dv, timeout} !== 2'b00) begin bad++; $display("FAIL tmo_pulse: got %b want 00", {m0_if.rd_dv, timeout}); end
    tick();
    bus_if.rd_dv = 1'b1; bus_if.rd_data = 16'h5555;
    tick(); clear_in(); smp();
    total++; if ({m0_if.rd_dv, m0_if.rd_data} !== {1'b0, 16'hDEAD}) begin bad++; $display("FAIL tmo_late_dv: got %b %h want 0 dead", m0_if.rd_dv, m0_if.rd_data); end
    total++; if ({tmo_n - t0, m0_dv_n - dv0} !== {32'd1, 32'd1}) begin bad++; $display("FAIL tmo_count: got tmo=%0d dv=%0d want 1 1", tmo_n - t0, m0_dv_n - dv0); end
    tick();
    // DV landing exactly in the timeout cycle wins.
    drive_req(0, 1'b0, 16'h00C2, 16'h0000);
    tick(); clear_in();
    tick();
    repeat (64) tick();
    bus_if.rd_dv = 1'b1; bus_if.rd_data = 16'h7777;
    tick(); clear_in(); smp();
    total++;
    if ({m0_if.rd_dv, timeout, m0_if.rd_data} !== {2'b10, 16'h7777}) begin
      bad++; $display("FAIL tmo_dv_wins: got dv=%b tmo=%b d=%h want 1 0 7777", m0_if.rd_dv, timeout, m0_if.rd_data);
    end
    tick(); smp();
    total++; if (tmo_n - t0 !== 1) begin bad++; $display("FAIL tmo_dv_wins_count: got %0d want 1", tmo_n - t0); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_read();
    int t0, dv0, dv1;
    drive_req(1, 1'b0, 16'h0D00, 16'h0000);
    tick(); clear_in();
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    total++; if (all_outs !== 74'd0) begin bad++; $display("FAIL midrd_reset: got %h want 0", all_outs); end
    tick(); tick();
    rst = 1'b0;
    t0 = tmo_n; dv0 = m0_dv_n; dv1 = m1_dv_n;
    drive_req(1, 1'b1, 16'h0ABC, 16'h0F0F);
    tick(); clear_in();
    tick(); smp();
    total++;
    if ({bus_if.cs, bus_if.wr_rd_n, bus_if.addr8, bus_if.wr_data, grant} !== {2'b11, 16'h0ABC, 16'h0F0F, 1'b1}) begin
      bad++; $display("FAIL midrd_new_wr: got cs=%b wr=%b a=%h d=%h g=%b want 1 1 0abc 0f0f 1",
                      bus_if.cs, bus_if.wr_rd_n, bus_if.addr8, bus_if.wr_data, grant);
    end
    tick();
    bus_if.rd_dv = 1'b1; bus_if.rd_data = 16'h9999;
    tick(); clear_in();
    repeat (70) tick();
    smp();
    total++;
    if ({m0_dv_n - dv0, m1_dv_n - dv1, tmo_n - t0} !== 96'd0 || m1_if.rd_data !== 16'h0000) begin
      bad++; $display("FAIL midrd_late_dv: got dv0=%0d dv1=%0d tmo=%0d d1=%h want 0 0 0 0000",
                      m0_dv_n - dv0, m1_dv_n - dv1, tmo_n - t0, m1_if.rd_data);
    end
  endtask

  initial begin
    m0_if.cs = 1'b0; m0_if.wr_rd_n = 1'b0; m0_if.addr8 = '0; m0_if.wr_data = '0;
    m1_if.cs = 1'b0; m1_if.wr_rd_n = 1'b0; m1_if.addr8 = '0; m1_if.wr_data = '0;
    bus_if.rd_dv = 1'b0; bus_if.rd_data = '0;
    test_reset();
    test_single_write();
    test_read_routing();
    test_contention();
    test_drop();
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
